ofm_tx_sched: RTL and testbench
===============================

Name: ofm_tx_sched

Overview:
Frame-granularity round-robin scheduler that shares the single 10GbE MAC TX AXI-stream between N outbound frame queues. Each queue is a pair of FWFT FIFOs: a ctrl FIFO holding one 64-bit descriptor per complete frame, and a data FIFO holding 73-bit beats {tlast, tkeep[7:0], tdata[63:0]}. The block grants one queue per frame, streams that queue's data beats to the MAC, pops its descriptor at end of frame, then re-arbitrates. It sits between the per-queue TX buffers and the MAC TX interface in tx_clk domain.

Parameters:
N_Q, 4, number of queues (2..8); all per-queue ports are N_Q-wide vectors, queue q at slice q
CNT_W, 32, width of frame counter output

Ports:
tx_clk  input  1  TX clock; sole clock
tx_reset_n  input  1  asynchronous active-low reset
sched_en  input  1  1 = new grants allowed; 0 = finish current frame, then idle
q_enable  input  N_Q  per-queue eligibility mask
ctrl_fifo_empty  input  N_Q  per-queue ctrl FIFO empty
ctrl_fifo_rdata  input  64*N_Q  per-queue head descriptor
ctrl_fifo_rden  output  N_Q  per-queue descriptor pop
data_fifo_empty  input  N_Q  per-queue data FIFO empty
data_fifo_rdata  input  73*N_Q  per-queue head beat
data_fifo_rden  output  N_Q  per-queue beat pop
tx_axis_mac_tdata  output  64  beat data
tx_axis_mac_tkeep  output  8  byte enables
tx_axis_mac_tvalid  output  1  beat valid
tx_axis_mac_tlast  output  1  last beat
tx_axis_mac_tuser  output  1  constant 0
tx_axis_mac_tready  input  1  MAC ready
cur_desc  output  64  descriptor of granted queue, latched at grant
grant_id  output  clog2(N_Q)  granted queue index
busy  output  1  1 while in S_DATA or S_DONE
frame_cnt  output  CNT_W  total frames completed, wraps

Behaviour:
- Reset (async on tx_reset_n low): state=S_IDLE, rr_ptr=0, grant_id=0, cur_desc=0, frame_cnt=0. All rden=0, tvalid=0, busy=0. tdata/tkeep/tlast are don't-care.
- req[q] = ~ctrl_fifo_empty[q] & q_enable[q] & sched_en.
- S_IDLE: if any req, pick the first set req at or after rr_ptr, scanning upward with wrap. Register grant_id and cur_desc on that edge and go to S_DATA.
- S_DATA: tvalid = ~data_fifo_empty[grant_id]. tdata/tkeep/tlast are combinational from data_fifo_rdata of grant_id. data_fifo_rden[grant_id] = tvalid & tready; all other rden bits are 0. On tvalid & tready & tlast go to S_DONE.
- S_DONE (one cycle): ctrl_fifo_rden[grant_id]=1 (combinational decode of state); frame_cnt+=1, wrapping at 2^CNT_W; rr_ptr = grant_id+1 mod N_Q; go to S_IDLE.
- Latency: descriptor visible in IDLE → first beat offered on the next cycle. Minimum inter-frame gap: 2 cycles (DONE, IDLE).
- tvalid is 0 in S_IDLE and S_DONE. Once tvalid is asserted it is held until the handshake, since FWFT head data is stable.
- Mid-frame data FIFO empty: tvalid drops and the block stalls in S_DATA. The frame is never abandoned.
- sched_en or q_enable deasserted mid-frame: the current frame completes; only the next grant is affected.
- A queue with ctrl non-empty but data empty is granted and waits; descriptor-before-data ordering is the writer's responsibility.
- Single eligible queue: it is re-granted back-to-back.
- Reset mid-frame: the FSM returns to IDLE immediately. FIFO contents are not flushed by this block.
- tvalid and tready both high for one beat with tlast: exactly one data pop and one later ctrl pop.

Decomposition:
- Shared package ofm_pkg: state enum (S_IDLE, S_DATA, S_DONE), beat field offsets (TLAST_BIT=72, TKEEP_MSB=71, TKEEP_LSB=64).
- Sub-module ofm_rr_pick: combinational round-robin picker with inputs req[N_Q] and ptr, outputs any and idx.

Test Plan:
- Q0 only, 1 frame of 3 beats, tready=1 → beats on cycles 2-4 after descriptor, tlast on beat 3, ctrl_fifo_rden[0] one pulse, frame_cnt=1.
- Q0..Q3 each with 2 frames queued → grant order 0,1,2,3,0,1,2,3, frame_cnt=8, no interleaving of beats between queues.
- Q1 frame of 4 beats, tready toggled 1010… → 4 data pops, tdata sequence intact, no duplicate or lost beat.
- Data FIFO of granted queue empty for 5 cycles mid-frame → tvalid=0 for those cycles, state held, resumes with the next beat.
- sched_en cleared during beat 2 of 4 → frame completes, then no new grant while Q2 still has a descriptor; re-set sched_en → Q2 granted.
- Assert tx_reset_n=0 mid-frame → all outputs return to reset values asynchronously; after release a pending Q0 frame is granted from rr_ptr=0.

Source files
------------

// File: rtl/ofm_pkg.sv
// ofm_pkg: shared definitions for the outbound frame TX scheduler.
//   - ofm_state_e : scheduler FSM states
//   - beat layout of a data FIFO word: {tlast, tkeep[7:0], tdata[63:0]}
//   - descriptor width of a ctrl FIFO word
package ofm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DONE
  } ofm_state_e;

  localparam int unsigned TDATA_MSB = 63;
  localparam int unsigned TKEEP_LSB = 64;
  localparam int unsigned TKEEP_MSB = 71;
  localparam int unsigned TLAST_BIT = 72;
  localparam int unsigned BEAT_W    = 73;
  localparam int unsigned DESC_W    = 64;

endpackage

// File: rtl/ofm_tx_sched_if.sv
// ofm_tx_sched_if: MAC TX AXI-stream bundle driven by the frame scheduler.
//   tx_axis_mac_tdata  [63:0]  beat data
//   tx_axis_mac_tkeep  [7:0]   byte enables
//   tx_axis_mac_tvalid         beat valid
//   tx_axis_mac_tlast          last beat of frame
//   tx_axis_mac_tuser          error flag, never raised by the scheduler
//   tx_axis_mac_tready         MAC ready
// Modports: master = scheduler side, slave = MAC side.
interface ofm_tx_sched_if;

  logic [63:0] tx_axis_mac_tdata;
  logic [7:0]  tx_axis_mac_tkeep;
  logic        tx_axis_mac_tvalid;
  logic        tx_axis_mac_tlast;
  logic        tx_axis_mac_tuser;
  logic        tx_axis_mac_tready;

  modport master (
    output tx_axis_mac_tdata,
    output tx_axis_mac_tkeep,
    output tx_axis_mac_tvalid,
    output tx_axis_mac_tlast,
    output tx_axis_mac_tuser,
    input  tx_axis_mac_tready
  );

  modport slave (
    input  tx_axis_mac_tdata,
    input  tx_axis_mac_tkeep,
    input  tx_axis_mac_tvalid,
    input  tx_axis_mac_tlast,
    input  tx_axis_mac_tuser,
    output tx_axis_mac_tready
  );

endinterface

// File: rtl/ofm_rr_pick.sv
// ofm_rr_pick: combinational round-robin picker.
//   req  [N_Q-1:0]          request vector
//   ptr  [clog2(N_Q)-1:0]   highest-priority index
//   any                     at least one request is set
//   idx  [clog2(N_Q)-1:0]   first set request at or after ptr, scanning
//                           upward with wrap (equals ptr when any=0)
module ofm_rr_pick #(
  parameter int unsigned N_Q = 4
) (
  input  logic [N_Q-1:0]         req,
  input  logic [$clog2(N_Q)-1:0] ptr,
  output logic                   any,
  output logic [$clog2(N_Q)-1:0] idx
);

  localparam int unsigned ID_W = $clog2(N_Q);

  int unsigned       cand;
  logic [ID_W-1:0]   cand_id;

  // Scan from the farthest offset down to offset 0 so the last hit written
  // is the one closest to ptr.
  always_comb begin
    any     = |req;
    idx     = ptr;
    cand    = 0;
    cand_id = '0;
    for (int unsigned i = N_Q; i > 0; i--) begin
      cand    = (32'(ptr) + i - 1) % N_Q;
      cand_id = ID_W'(cand);
      if (req[cand_id]) begin
        idx = cand_id;
      end
    end
  end

endmodule

// File: rtl/ofm_tx_sched.sv
// ofm_tx_sched: frame-granularity round-robin scheduler sharing the MAC TX
// AXI-stream between N_Q outbound frame queues (FWFT ctrl + data FIFOs).
//
// Ports:
//   tx_clk, tx_reset_n        clock, async active-low reset
//   sched_en                  allow new grants (current frame always finishes)
//   q_enable        [N_Q]     per-queue eligibility
//   ctrl_fifo_empty [N_Q]     per-queue descriptor FIFO empty
//   ctrl_fifo_rdata [64*N_Q]  per-queue head descriptor
//   ctrl_fifo_rden  [N_Q]     descriptor pop (one cycle after frame end)
//   data_fifo_empty [N_Q]     per-queue beat FIFO empty
//   data_fifo_rdata [73*N_Q]  per-queue head beat {tlast, tkeep, tdata}
//   data_fifo_rden  [N_Q]     beat pop (on MAC handshake)
//   mac                       MAC TX AXI-stream (master modport)
//   cur_desc        [64]      descriptor of granted queue, latched at grant
//   grant_id        [clog2]   granted queue index
//   busy                      frame in progress (data or done phase)
//   frame_cnt       [CNT_W]   completed frames, wrapping
module ofm_tx_sched
  import ofm_pkg::*;
#(
  parameter int unsigned N_Q   = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    tx_clk,
  input  logic                    tx_reset_n,
  input  logic                    sched_en,
  input  logic [N_Q-1:0]          q_enable,
  input  logic [N_Q-1:0]          ctrl_fifo_empty,
  input  logic [64*N_Q-1:0]       ctrl_fifo_rdata,
  output logic [N_Q-1:0]          ctrl_fifo_rden,
  input  logic [N_Q-1:0]          data_fifo_empty,
  input  logic [73*N_Q-1:0]       data_fifo_rdata,
  output logic [N_Q-1:0]          data_fifo_rden,
  ofm_tx_sched_if.master          mac,
  output logic [63:0]             cur_desc,
  output logic [$clog2(N_Q)-1:0]  grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int unsigned ID_W = $clog2(N_Q);

  ofm_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_next;
  logic [N_Q-1:0]    req;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              grant_load;
  logic              tvalid;
  logic [BEAT_W-1:0] head_beat;
  logic [DESC_W-1:0] head_desc;

  assign req = ~ctrl_fifo_empty & q_enable & {N_Q{sched_en}};

  ofm_rr_pick #(
    .N_Q (N_Q)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Head beat of the granted queue drives the stream directly; FWFT keeps it
  // stable until popped, so tvalid never drops before the handshake.
  assign head_beat = data_fifo_rdata[grant_id*BEAT_W +: BEAT_W];
  assign head_desc = ctrl_fifo_rdata[pick_idx*DESC_W +: DESC_W];

  assign mac.tx_axis_mac_tdata  = head_beat[TDATA_MSB:0];
  assign mac.tx_axis_mac_tkeep  = head_beat[TKEEP_MSB:TKEEP_LSB];
  assign mac.tx_axis_mac_tlast  = head_beat[TLAST_BIT];
  assign mac.tx_axis_mac_tuser  = 1'b0;
  assign mac.tx_axis_mac_tvalid = tvalid;

  assign busy = (state_q == S_DATA) || (state_q == S_DONE);

  assign rr_ptr_next = (grant_id == ID_W'(N_Q - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    state_d        = state_q;
    tvalid         = 1'b0;
    grant_load     = 1'b0;
    data_fifo_rden = '0;
    ctrl_fifo_rden = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_load = 1'b1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        tvalid = ~data_fifo_empty[grant_id];
        if (tvalid && mac.tx_axis_mac_tready) begin
          data_fifo_rden[grant_id] = 1'b1;
          if (head_beat[TLAST_BIT]) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ctrl_fifo_rden[grant_id] = 1'b1;
        state_d                  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_reset_n) begin
    if (!tx_reset_n) begin
      state_q   <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      cur_desc  <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        grant_id <= pick_idx;
        cur_desc <= head_desc;
      end
      if (state_q == S_DONE) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        rr_ptr    <= rr_ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_ofm_tx_sched.sv
module tb_ofm_tx_sched;

  localparam int N = 4;

  logic            tx_clk = 1'b0;
  logic            tx_reset_n = 1'b0;
  logic            sched_en;
  logic [N-1:0]    q_enable;
  logic [N-1:0]    ctrl_fifo_empty;
  logic [64*N-1:0] ctrl_fifo_rdata;
  logic [N-1:0]    ctrl_fifo_rden;
  logic [N-1:0]    data_fifo_empty;
  logic [73*N-1:0] data_fifo_rdata;
  logic [N-1:0]    data_fifo_rden;
  logic [63:0]     cur_desc;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     frame_cnt;

  ofm_tx_sched_if mac_if ();

  ofm_tx_sched #(
    .N_Q   (N),
    .CNT_W (32)
  ) dut (
    .tx_clk          (tx_clk),
    .tx_reset_n      (tx_reset_n),
    .sched_en        (sched_en),
    .q_enable        (q_enable),
    .ctrl_fifo_empty (ctrl_fifo_empty),
    .ctrl_fifo_rdata (ctrl_fifo_rdata),
    .ctrl_fifo_rden  (ctrl_fifo_rden),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rden  (data_fifo_rden),
    .mac             (mac_if),
    .cur_desc        (cur_desc),
    .grant_id        (grant_id),
    .busy            (busy),
    .frame_cnt       (frame_cnt)
  );

  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;

  // Queue-side FIFO contents (the bench owns the FIFOs)
  logic [63:0] dq[N][$];
  logic [72:0] bq[N][$];

  // Reference model: frame-level round robin
  int          m_phase;   // 0 waiting for a grant, 1 streaming, 2 frame end
  int          m_q;
  int          m_ptr;
  logic [31:0] m_cnt;
  logic [63:0] m_desc;
  int          grant_log[$];
  bit          rand_ready;
  logic        obs_tv;
  logic [N-1:0] obs_cr, obs_dr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_q = 0; m_ptr = 0; m_cnt = '0; m_desc = '0;
  endtask

  task automatic push_frame(input int q, input int nb);
    logic [63:0] d;
    logic [7:0]  k;
    d = {8'(q), 24'($urandom), 32'($urandom)};
    dq[q].push_back(d);
    for (int b = 0; b < nb; b++) begin
      k = (b == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      bq[q].push_back({(b == nb - 1), k, 8'(q), 8'(b), 48'({$urandom, $urandom})});
    end
  endtask

  task automatic apply();
    for (int q = 0; q < N; q++) begin
      ctrl_fifo_empty[q] = (dq[q].size() == 0);
      ctrl_fifo_rdata[q*64 +: 64] = (dq[q].size() == 0) ? 64'h0 : dq[q][0];
      data_fifo_empty[q] = (bq[q].size() == 0);
      data_fifo_rdata[q*73 +: 73] = (bq[q].size() == 0) ? 73'h0 : bq[q][0];
    end
  endtask

  task automatic model_step();
    logic [N-1:0] exp_d, exp_c;
    logic [72:0]  b;
    bit           v, hs, found;
    int           q;
    exp_d = '0; exp_c = '0;
    obs_tv = mac_if.tx_axis_mac_tvalid;
    obs_cr = ctrl_fifo_rden;
    obs_dr = data_fifo_rden;
    check("frame_cnt", frame_cnt, m_cnt);
    check("grant_id", 64'(grant_id), 64'(m_q));
    check("cur_desc", cur_desc, m_desc);
    check("tuser", 64'(mac_if.tx_axis_mac_tuser), 64'd0);
    case (m_phase)
      0: begin
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tvalid", 64'(obs_tv), 64'd0);
        check("idle_data_rden", 64'(obs_dr), 64'd0);
        check("idle_ctrl_rden", 64'(obs_cr), 64'd0);
        found = 0;
        for (int i = 0; i < N; i++) begin
          q = (m_ptr + i) % N;
          if (!found && dq[q].size() > 0 && q_enable[q] && sched_en) begin
            found = 1; m_q = q;
          end
        end
        if (found) begin
          m_desc = dq[m_q][0];
          grant_log.push_back(m_q);
          m_phase = 1;
        end
      end
      1: begin
        check("data_busy", 64'(busy), 64'd1);
        v = (bq[m_q].size() > 0);
        check("data_tvalid", 64'(obs_tv), 64'(v));
        if (v) begin
          b = bq[m_q][0];
          check("tdata", mac_if.tx_axis_mac_tdata, b[63:0]);
          check("tkeep", 64'(mac_if.tx_axis_mac_tkeep), 64'(b[71:64]));
          check("tlast", 64'(mac_if.tx_axis_mac_tlast), 64'(b[72]));
        end
        hs = v && mac_if.tx_axis_mac_tready;
        exp_d[m_q] = hs;
        check("data_data_rden", 64'(obs_dr), 64'(exp_d));
        check("data_ctrl_rden", 64'(obs_cr), 64'd0);
        if (hs) begin
          b = bq[m_q].pop_front();
          if (b[72]) m_phase = 2;
        end
      end
      default: begin
        check("done_busy", 64'(busy), 64'd1);
        check("done_tvalid", 64'(obs_tv), 64'd0);
        exp_c[m_q] = 1'b1;
        check("done_ctrl_rden", 64'(obs_cr), 64'(exp_c));
        check("done_data_rden", 64'(obs_dr), 64'd0);
        void'(dq[m_q].pop_front());
        m_cnt   = m_cnt + 1;
        m_ptr   = (m_q + 1) % N;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic step();
    if (rand_ready) mac_if.tx_axis_mac_tready = 1'($urandom);
    apply();
    @(negedge tx_clk);
    model_step();
    @(posedge tx_clk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int q = 0; q < N; q++)
      if (dq[q].size() != 0 || bq[q].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string tag, input int max);
    bit done;
    done = 0;
    for (int i = 0; i < max; i++) begin
      if (all_empty() && m_phase == 0) begin
        done = 1;
        break;
      end
      step();
    end
    if (!done) done = all_empty() && (m_phase == 0);
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    logic [7:0]  tv_pat, cr_pat;
    logic [72:0] hold[$];
    int          base, pops, cnt2, tot;
    bit          reached;

    sched_en = 1'b1;
    q_enable = '1;
    mac_if.tx_axis_mac_tready = 1'b1;
    rand_ready = 0;
    model_reset();
    apply();

    // Reset values
    repeat (2) @(posedge tx_clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tvalid", 64'(mac_if.tx_axis_mac_tvalid), 64'd0);
    check("rst_frame_cnt", frame_cnt, 64'd0);
    check("rst_rden", 64'({ctrl_fifo_rden, data_fifo_rden}), 64'd0);
    @(posedge tx_clk);
    #3 tx_reset_n = 1'b1;

    // Single 3-beat frame on Q0: beats on steps 1..3, ctrl pop on step 4
    push_frame(0, 3);
    tv_pat = '0; cr_pat = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      tv_pat[i] = obs_tv;
      cr_pat[i] = obs_cr[0];
    end
    check("a_tvalid_pattern", 64'(tv_pat), 64'h0E);
    check("a_ctrl_pop_pattern", 64'(cr_pat), 64'h10);
    check("a_frame_cnt", frame_cnt, 64'd1);

    // Bring rr pointer back to 0, then two frames on every queue
    push_frame(3, 2);
    drain("b_pre_drain", 50);
    base = grant_log.size();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++)
        push_frame(q, $urandom_range(1, 5));
    rand_ready = 1;
    drain("b_drain", 600);
    rand_ready = 0;
    check("b_grant_count", 64'(grant_log.size() - base), 64'd8);
    for (int i = 0; i < 8; i++)
      check("b_grant_order", 64'(grant_log[base + i]), 64'(i % 4));
    check("b_frame_cnt", frame_cnt, 64'd10);

    // Q1, 4 beats, tready alternating 1/0
    mac_if.tx_axis_mac_tready = 1'b1;
    push_frame(1, 4);
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_dr[1]) pops++;
      mac_if.tx_axis_mac_tready = ~mac_if.tx_axis_mac_tready;
    end
    check("c_data_pops", 64'(pops), 64'd4);
    mac_if.tx_axis_mac_tready = 1'b1;
    drain("c_drain", 20);

    // Data FIFO runs dry mid-frame for 5 cycles
    push_frame(1, 4);
    hold.push_front(bq[1].pop_back());
    hold.push_front(bq[1].pop_back());
    reached = 0;
    for (int i = 0; i < 10; i++) begin
      if (bq[1].size() == 0 && m_phase == 1) begin
        reached = 1;
        break;
      end
      step();
    end
    check("d_stall_reached", 64'(reached), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("d_stall_tvalid", 64'(obs_tv), 64'd0);
      check("d_stall_busy", 64'(busy), 64'd1);
    end
    while (hold.size() > 0) bq[1].push_back(hold.pop_front());
    drain("d_drain", 20);

    // sched_en dropped during beat 2 of 4: frame finishes, no new grant
    base = grant_log.size();
    push_frame(2, 4);
    push_frame(2, 3);
    step();
    step();
    sched_en = 1'b0;
    repeat (12) step();
    check("e_idle_busy", 64'(busy), 64'd0);
    check("e_pending_desc", 64'(dq[2].size()), 64'd1);
    check("e_grants_while_off", 64'(grant_log.size() - base), 64'd1);
    sched_en = 1'b1;
    drain("e_drain", 30);
    check("e_regrant_q2", 64'(grant_log[grant_log.size() - 1]), 64'd2);

    // Reset mid-frame: async return to reset values, rr restarts at 0
    push_frame(1, 6);
    repeat (3) step();
    #2 tx_reset_n = 1'b0;
    #1;
    check("f_rst_busy", 64'(busy), 64'd0);
    check("f_rst_tvalid", 64'(mac_if.tx_axis_mac_tvalid), 64'd0);
    check("f_rst_rden", 64'({ctrl_fifo_rden, data_fifo_rden}), 64'd0);
    check("f_rst_frame_cnt", frame_cnt, 64'd0);
    check("f_rst_grant_id", 64'(grant_id), 64'd0);
    check("f_rst_cur_desc", cur_desc, 64'd0);
    model_reset();
    for (int q = 0; q < N; q++) begin
      dq[q].delete();
      bq[q].delete();
    end
    push_frame(3, 2);
    push_frame(0, 2);
    apply();
    @(posedge tx_clk);
    @(posedge tx_clk);
    #3 tx_reset_n = 1'b1;
    base = grant_log.size();
    drain("f_drain", 40);
    check("f_first_grant", 64'(grant_log[base]), 64'd0);
    check("f_second_grant", 64'(grant_log[base + 1]), 64'd3);

    // Randomized traffic with enable churn
    rand_ready = 1;
    for (int i = 0; i < 800; i++) begin
      tot = 0;
      for (int q = 0; q < N; q++) tot += dq[q].size();
      if ($urandom_range(0, 5) == 0 && tot < 6)
        push_frame($urandom_range(0, N - 1), $urandom_range(1, 6));
      if ($urandom_range(0, 19) == 0) q_enable = 4'($urandom);
      if ($urandom_range(0, 24) == 0) sched_en = ($urandom_range(0, 7) != 0);
      step();
    end
    q_enable = '1;
    sched_en = 1'b1;
    drain("g_drain", 2000);
    cnt2 = int'(m_cnt);
    check("g_frame_cnt", frame_cnt, 64'(cnt2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
